// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the two-digit multiplexed hex display driver.
package hex_scan_pkg;

  typedef enum logic [1:0] {
    S_D0   = 2'd0,
    S_GAP0 = 2'd1,
    S_D1   = 2'd2,
    S_GAP1 = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment patterns, bit order g..a (bit0 = a), indexed by nibble.
  localparam logic [6:0] SEG7_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment decode.
module hex_to_seg7
  import hex_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG7_LUT[nibble];

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed 2-digit hex display driver with inter-digit blanking,
// frame-boundary data capture and optional blink.
module hex_scan_driver
  import hex_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int GAP_CYC      = 500,
  parameter int BLINK_FRAMES = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic [1:0] dp_in,
  input  logic       blink_en,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [1:0] dig_en_n,
  output logic       frame_done
);

  localparam int MAX_LEN = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [FW-1:0] frame_cnt, frame_nxt;
  logic          blink_off, blink_off_nxt;
  logic [7:0]    shadow, shadow_nxt;
  logic [1:0]    shadow_dp, shadow_dp_nxt;
  logic          phase_end, boundary, lit, dp_sel;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    frame_nxt     = frame_cnt;
    blink_off_nxt = blink_off;

    if (state == S_D0 || state == S_D1) phase_end = (cnt == CW'(SCAN_DIV - 1));
    else                                phase_end = (cnt == CW'(GAP_CYC - 1));

    if (phase_end) begin
      unique case (state)
        S_D0:    state_nxt = S_GAP0;
        S_GAP0:  state_nxt = S_D1;
        S_D1:    state_nxt = S_GAP1;
        default: state_nxt = S_D0;
      endcase
    end

    boundary      = phase_end && (state == S_GAP1);
    shadow_nxt    = boundary ? data_in : shadow;
    shadow_dp_nxt = boundary ? dp_in   : shadow_dp;

    if (boundary) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_nxt     = '0;
        blink_off_nxt = ~blink_off;
      end else begin
        frame_nxt = frame_cnt + 1'b1;
      end
    end

    // Decode from next-state values so the first lit cycle already shows the freshly loaded byte.
    lit    = (state_nxt == S_D0 || state_nxt == S_D1) && !(blink_en && blink_off_nxt);
    nibble = (state_nxt == S_D1) ? shadow_nxt[7:4] : shadow_nxt[3:0];
    dp_sel = (state_nxt == S_D1) ? shadow_dp_nxt[1] : shadow_dp_nxt[0];
  end

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg_n  (seg_dec)
  );

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_GAP1;
      cnt        <= '0;
      frame_cnt  <= '0;
      blink_off  <= 1'b0;
      shadow     <= 8'h00;
      shadow_dp  <= 2'b00;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      dig_en_n   <= 2'b11;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= phase_end ? '0 : cnt + 1'b1;
      frame_cnt  <= frame_nxt;
      blink_off  <= blink_off_nxt;
      shadow     <= shadow_nxt;
      shadow_dp  <= shadow_dp_nxt;
      frame_done <= boundary;
      seg_n      <= lit ? seg_dec : SEG_BLANK;
      dp_n       <= lit ? ~dp_sel : 1'b1;
      if (!lit)                   dig_en_n <= 2'b11;
      else if (state_nxt == S_D0) dig_en_n <= 2'b10;
      else                        dig_en_n <= 2'b01;
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench: cycle-position reference model of the scan, with
// directed scenarios plus randomized data, decimal point and blink stimulus.
module tb_hex_scan_driver;

  localparam int SCAN_DIV     = 4;
  localparam int GAP_CYC      = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 2 * (SCAN_DIV + GAP_CYC);

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic [1:0] dp_in;
  logic       blink_en;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [1:0] dig_en_n;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: edges since reset release and the captured byte.
  int         m_k      = 0;
  int         m_pos    = -1;
  bit         m_off    = 0;
  logic [7:0] m_shadow = 8'h00;
  logic [1:0] m_sdp    = 2'b00;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  hex_scan_driver #(
    .SCAN_DIV     (SCAN_DIV),
    .GAP_CYC      (GAP_CYC),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blink_en   (blink_en),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .dig_en_n   (dig_en_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d: observed %h expected %h", tag, m_k, got, exp);
    end
  endtask

  // Advance one clock, update the model from the inputs seen at that edge, then compare.
  task automatic step();
    logic [6:0] e_seg;
    logic       e_dp;
    logic [1:0] e_dig;
    logic       e_fd;
    bit         d0, d1, lit;
    int         b;
    @(posedge clk);
    e_seg = 7'h7F; e_dp = 1'b1; e_dig = 2'b11; e_fd = 1'b0;
    if (reset) begin
      m_k = 0; m_pos = -1; m_off = 0; m_shadow = 8'h00; m_sdp = 2'b00;
    end else begin
      m_k++;
      if (m_k >= GAP_CYC) begin
        m_pos = (m_k - GAP_CYC) % FRAME;
        b     = (m_k - GAP_CYC) / FRAME + 1;
        if (m_pos == 0) begin
          m_shadow = data_in;
          m_sdp    = dp_in;
        end
        m_off = ((b / BLINK_FRAMES) % 2) == 1;
        e_fd  = (m_pos == 0);
        d0    = m_pos < SCAN_DIV;
        d1    = (m_pos >= SCAN_DIV + GAP_CYC) && (m_pos < 2 * SCAN_DIV + GAP_CYC);
        lit   = (d0 || d1) && !(blink_en && m_off);
        if (lit) begin
          e_dig = d0 ? 2'b10 : 2'b01;
          e_seg = d0 ? seg_tab[m_shadow[3:0]] : seg_tab[m_shadow[7:4]];
          e_dp  = d0 ? ~m_sdp[0] : ~m_sdp[1];
        end
      end
    end
    #1;
    check("seg_n",      {1'b0, seg_n},  {1'b0, e_seg});
    check("dp_n",       {7'b0, dp_n},   {7'b0, e_dp});
    check("dig_en_n",   {6'b0, dig_en_n}, {6'b0, e_dig});
    check("frame_done", {7'b0, frame_done}, {7'b0, e_fd});
    n_checks++;
    assert (dig_en_n !== 2'b00) else begin
      n_fail++;
      $error("FAIL both_digits_on k=%0d: observed %b expected not 00", m_k, dig_en_n);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; data_in = 8'hA5; dp_in = 2'b00; blink_en = 1'b0;
    @(negedge clk);
    run(2);
    reset = 1'b0;

    // Basic scan with A5 and periodic frame_done.
    run(20 + 7);
    // Now inside digit 1 of a frame: change data, the lit digit must not tear.
    data_in = 8'h3F;
    run(20);

    // Decimal point on digit 1 only, taking effect at the next boundary.
    dp_in = 2'b10;
    run(20);

    // Randomized data and decimal points, changed at arbitrary cycles.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) data_in = 8'($urandom);
      if ($urandom_range(0, 5) == 0) dp_in   = 2'($urandom);
      step();
    end

    // Blink with random data.
    blink_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) data_in = 8'($urandom);
      step();
    end

    // Drop blink_en during an OFF phase while a digit slot is active.
    for (int i = 0; i < 4 * FRAME && !(m_off && m_pos >= 1 && m_pos < SCAN_DIV); i++) step();
    check("reached_off_phase", {7'b0, m_off}, 8'h01);
    blink_en = 1'b0;
    run(2 * FRAME);

    // Random blink_en toggling on top of random data.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 6) == 0) blink_en = ~blink_en;
      if ($urandom_range(0, 3) == 0) data_in  = 8'($urandom);
      step();
    end
    blink_en = 1'b0;

    // One-cycle reset while digit 0 is lit, then the first scenario again.
    for (int i = 0; i < 2 * FRAME && !(m_pos >= 1 && m_pos < SCAN_DIV); i++) step();
    check("reached_digit0", {7'b0, 1'(m_pos >= 1 && m_pos < SCAN_DIV)}, 8'h01);
    reset = 1'b1; data_in = 8'hA5; dp_in = 2'b00;
    step();
    reset = 1'b0;
    run(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
